mem_access_unit: RTL and testbench

Parametrised memory-access unit holding the MAR and MDR of the bus-based CPU datapath. It runs a multi-cycle, handshaked read or write to a synchronous RAM with configurable wait states, ready-based completion and a timeout. It sits between the shared 32-bit bus, the control unit (start/busy/done) and the RAM. Unlike the single-cycle MAR/MDR pair it supports writes, slow memories and error reporting.

---
 rtl/mem_access_unit_if.sv | 44 ++++
 rtl/mem_access_unit.sv | 166 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundle of the memory-access unit's datapath, control and RAM-side signals.
// Handshake: start_read/start_write are single-cycle requests that are only
// accepted while the unit is idle (busy and done both low); once accepted,
// mem_rd/mem_wr stay high with stable mem_addr/mem_wdata until mem_ready is
// sampled high in the access phase (or the timeout expires), after which done
// pulses for exactly one cycle, coincident with err on a timeout.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic [DATA_W-1:0] bus_in;
  logic              MAR_enable;
  logic              MDR_enable;
  logic              start_read;
  logic              start_write;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] MAR_data_out;
  logic [DATA_W-1:0] MDR_data_out;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        state_dbg;

  // The unit itself
  modport slave (
    input  bus_in, MAR_enable, MDR_enable, start_read, start_write,
    input  mem_rdata, mem_ready,
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    output MAR_data_out, MDR_data_out, busy, done, err, state_dbg
  );

  // Control unit / RAM side driving the unit
  modport master (
    output bus_in, MAR_enable, MDR_enable, start_read, start_write,
    output mem_rdata, mem_ready,
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    input  MAR_data_out, MDR_data_out, busy, done, err, state_dbg
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access unit: owns MAR/MDR and runs one multi-cycle read or write to
// a synchronous RAM with fixed wait states, ready-based completion and a
// timeout. All outputs are registered.
module mem_access_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 16
) (
  input  logic           clock,
  input  logic           clear,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Wait counter preload: last wait cycle index; unused when WAIT_STATES is 0.
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
  // Timeout fires on the edge where the miss count would reach TIMEOUT.
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              timeout_hit;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              start_any;

  assign start_any = bus.start_read | bus.start_write;

  // Next-state logic: idle -> (wait) -> access -> done -> idle.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_any) state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.mem_ready) begin
          state_d = S_DONE;
        end else if (tcnt_q == TO_LAST) begin
          state_d     = S_DONE;
          timeout_hit = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-values, derived from the next state so they register cleanly.
  always_comb begin
    op_wr_d = op_wr_q;
    // Read wins when both starts arrive together.
    if (state_q == S_IDLE && start_any) op_wr_d = bus.start_write & ~bus.start_read;
    busy_d = (state_d == S_WAIT) || (state_d == S_ACCESS);
    rd_d   = busy_d & ~op_wr_d;
    wr_d   = busy_d & op_wr_d;
    done_d = (state_d == S_DONE);
    err_d  = timeout_hit;
  end

  // Datapath next-values: MAR/MDR loads, access latching, counters.
  always_comb begin
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.MAR_enable) mar_d = bus.bus_in;
        if (bus.MDR_enable) mdr_d = bus.bus_in;
        if (start_any) begin
          // Forwarded values: a coincident load is what the access uses.
          addr_d  = mar_d[ADDR_W-1:0];
          wdata_d = mdr_d;
          wcnt_d  = WAIT_LAST;
          tcnt_d  = 8'd0;
        end
      end
      S_WAIT: begin
        if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
      end
      S_ACCESS: begin
        if (bus.mem_ready) begin
          if (!op_wr_q) mdr_d = bus.mem_rdata;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // State and strobe registers.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      mar_q   <= '0;
      mdr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_rd       = rd_q;
  assign bus.mem_wr       = wr_q;
  assign bus.MAR_data_out = mar_q;
  assign bus.MDR_data_out = mdr_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level
// model that reasons in edge counts relative to the accepting edge.
module tb_mem_access_unit;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int W  = 1;
  localparam int T  = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  mem_access_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus_if ();

  mem_access_unit #(
    .DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(W), .TIMEOUT(T)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus_if)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 access in flight, 2 completion cycle
  int                m_phase = 0;
  int                m_cyc   = 0;
  int                m_acc_e = 0;
  bit                m_wr    = 1'b0;
  bit                m_err   = 1'b0;
  logic [DW-1:0]     m_mar   = '0;
  logic [DW-1:0]     m_mdr   = '0;
  logic [DW-1:0]     m_wdata = '0;
  logic [AW-1:0]     m_addr  = '0;
  logic [DW-1:0]     exp_q[$];

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      m_phase = 0; m_mar = '0; m_mdr = '0; m_wdata = '0; m_addr = '0;
      m_wr = 1'b0; m_err = 1'b0;
      exp_q.delete();
    end else begin
      m_cyc++;
      case (m_phase)
        0: begin
          if (bus_if.MAR_enable) m_mar = bus_if.bus_in;
          if (bus_if.MDR_enable) m_mdr = bus_if.bus_in;
          if (bus_if.start_read || bus_if.start_write) begin
            m_wr    = !bus_if.start_read;
            m_addr  = m_mar[AW-1:0];
            m_wdata = m_mdr;
            m_acc_e = m_cyc;
            m_phase = 1;
          end
        end
        1: begin
          // Ready is only looked at on edges E+W+1 onwards; timeout at E+W+T.
          if (m_cyc - m_acc_e >= W + 1) begin
            if (bus_if.mem_ready) begin
              if (!m_wr) begin
                m_mdr = bus_if.mem_rdata;
                exp_q.push_back(bus_if.mem_rdata);
              end
              m_err   = 1'b0;
              m_phase = 2;
            end else if (m_cyc - m_acc_e == W + T) begin
              m_err   = 1'b1;
              m_phase = 2;
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    check("mem_rd",   {31'd0, bus_if.mem_rd},   {31'd0, (m_phase == 1) && !m_wr});
    check("mem_wr",   {31'd0, bus_if.mem_wr},   {31'd0, (m_phase == 1) && m_wr});
    check("busy",     {31'd0, bus_if.busy},     {31'd0, m_phase == 1});
    check("done",     {31'd0, bus_if.done},     {31'd0, m_phase == 2});
    check("err",      {31'd0, bus_if.err},      {31'd0, (m_phase == 2) && m_err});
    check("MAR",      bus_if.MAR_data_out, m_mar);
    check("MDR",      bus_if.MDR_data_out, m_mdr);
    check("mem_addr", {{(DW-AW){1'b0}}, bus_if.mem_addr}, {{(DW-AW){1'b0}}, m_addr});
    check("mem_wdata", bus_if.mem_wdata, m_wdata);
    if (m_phase == 2 && !m_wr && !m_err) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_read: read completion with empty expected queue (t=%0t)", $time);
      end else begin
        check("sb_read_mdr", bus_if.MDR_data_out, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic drive_quiet();
    bus_if.MAR_enable  = 1'b0;
    bus_if.MDR_enable  = 1'b0;
    bus_if.start_read  = 1'b0;
    bus_if.start_write = 1'b0;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ready_pct;
    bus_if.bus_in    = '0;
    bus_if.mem_rdata = '0;
    bus_if.mem_ready = 1'b0;
    drive_quiet();

    // Reset state
    step(); step();
    check("rst_MAR", bus_if.MAR_data_out, 32'h0);
    check("rst_MDR", bus_if.MDR_data_out, 32'h0);
    chk1("rst_busy", bus_if.busy, 1'b0);
    chk1("rst_done", bus_if.done, 1'b0);
    clear = 1'b1;
    step();

    // Read, W=1, ready high, MAR forwarded from bus
    bus_if.bus_in = 32'h0000_0005; bus_if.MAR_enable = 1'b1; bus_if.start_read = 1'b1;
    bus_if.mem_ready = 1'b1; bus_if.mem_rdata = 32'hDEAD_BEEF;
    step();                                     // edge E
    drive_quiet();
    chk1("rd_E_rd", bus_if.mem_rd, 1'b1);
    check("rd_E_mar", bus_if.MAR_data_out, 32'h5);
    check("rd_E_addr", {23'd0, bus_if.mem_addr}, 32'h5);
    step();                                     // E+1
    chk1("rd_E1_rd", bus_if.mem_rd, 1'b1);
    chk1("rd_E1_done", bus_if.done, 1'b0);
    step();                                     // E+2
    chk1("rd_E2_rd", bus_if.mem_rd, 1'b0);
    chk1("rd_E2_done", bus_if.done, 1'b1);
    check("rd_E2_mdr", bus_if.MDR_data_out, 32'hDEAD_BEEF);
    step();                                     // E+3
    chk1("rd_E3_done", bus_if.done, 1'b0);

    // Write with MDR forwarding
    bus_if.bus_in = 32'h1234_5678; bus_if.MDR_enable = 1'b1; bus_if.start_write = 1'b1;
    step();
    drive_quiet();
    chk1("wr_E_wr", bus_if.mem_wr, 1'b1);
    chk1("wr_E_rd", bus_if.mem_rd, 1'b0);
    check("wr_E_wdata", bus_if.mem_wdata, 32'h1234_5678);
    check("wr_E_mdr", bus_if.MDR_data_out, 32'h1234_5678);
    step(); step();
    chk1("wr_E2_done", bus_if.done, 1'b1);
    chk1("wr_E2_wr", bus_if.mem_wr, 1'b0);
    step();

    // Ready delayed 3 cycles: strobe W+1+3 = 5 cycles, done at E+5
    bus_if.mem_ready = 1'b0; bus_if.mem_rdata = 32'hCAFE_0001;
    bus_if.bus_in = 32'h0000_01F3; bus_if.MAR_enable = 1'b1; bus_if.start_read = 1'b1;
    step();                                     // E
    drive_quiet();
    chk1("dly_E0_rd", bus_if.mem_rd, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk1("dly_rd_held", bus_if.mem_rd, 1'b1);
      check("dly_addr", {23'd0, bus_if.mem_addr}, 32'h1F3);
    end
    bus_if.mem_ready = 1'b1;
    step();                                     // E+5
    chk1("dly_done", bus_if.done, 1'b1);
    chk1("dly_rd_off", bus_if.mem_rd, 1'b0);
    check("dly_mdr", bus_if.MDR_data_out, 32'hCAFE_0001);
    step();

    // Timeout: ready never high, done/err at E+W+T = E+17
    bus_if.mem_ready = 1'b0; bus_if.mem_rdata = 32'h1111_1111; bus_if.start_read = 1'b1;
    step();                                     // E
    drive_quiet();
    repeat (16) step();                         // E+16
    chk1("to_E16_done", bus_if.done, 1'b0);
    chk1("to_E16_busy", bus_if.busy, 1'b1);
    step();                                     // E+17
    chk1("to_done", bus_if.done, 1'b1);
    chk1("to_err", bus_if.err, 1'b1);
    check("to_mdr_kept", bus_if.MDR_data_out, 32'hCAFE_0001);
    step();
    chk1("to_err_off", bus_if.err, 1'b0);
    bus_if.start_read = 1'b1; bus_if.mem_ready = 1'b1;
    step();
    drive_quiet();
    chk1("to_next_start", bus_if.busy, 1'b1);
    step(); step(); step();

    // Both starts plus MAR_enable while busy
    bus_if.mem_ready = 1'b0;
    bus_if.bus_in = 32'h0000_0042; bus_if.MAR_enable = 1'b1;
    bus_if.start_read = 1'b1; bus_if.start_write = 1'b1;
    step();                                     // E
    bus_if.start_read = 1'b0; bus_if.start_write = 1'b0;
    bus_if.bus_in = 32'hAAAA_AAAA;              // MAR_enable still high, must be ignored
    chk1("both_rd", bus_if.mem_rd, 1'b1);
    chk1("both_wr", bus_if.mem_wr, 1'b0);
    step();                                     // E+1
    check("both_mar_frozen", bus_if.MAR_data_out, 32'h42);
    drive_quiet();
    bus_if.mem_ready = 1'b1;
    step();                                     // E+2
    chk1("both_done", bus_if.done, 1'b1);
    step();

    // Asynchronous clear mid-access
    bus_if.mem_ready = 1'b0; bus_if.start_read = 1'b1;
    step();
    drive_quiet();
    step(); step();                             // now in the access phase
    #1 clear = 1'b0;
    #1;
    chk1("clr_rd", bus_if.mem_rd, 1'b0);
    chk1("clr_busy", bus_if.busy, 1'b0);
    check("clr_mar", bus_if.MAR_data_out, 32'h0);
    check("clr_mdr", bus_if.MDR_data_out, 32'h0);
    step();
    clear = 1'b1;
    step();
    chk1("clr_idle_busy", bus_if.busy, 1'b0);
    bus_if.start_read = 1'b1; bus_if.mem_ready = 1'b1;
    step();
    drive_quiet();
    chk1("clr_restart", bus_if.busy, 1'b1);
    step(); step(); step();

    // Randomized traffic
    for (int blk = 0; blk < 4; blk++) begin
      case (blk)
        0: ready_pct = 100;
        1: ready_pct = 50;
        2: ready_pct = 0;
        default: ready_pct = 20;
      endcase
      for (int c = 0; c < 120; c++) begin
        bus_if.bus_in      = $urandom;
        bus_if.mem_rdata   = $urandom;
        bus_if.MAR_enable  = ($urandom_range(0, 3) == 0);
        bus_if.MDR_enable  = ($urandom_range(0, 3) == 0);
        bus_if.start_read  = ($urandom_range(0, 3) == 0);
        bus_if.start_write = ($urandom_range(0, 3) == 0);
        bus_if.mem_ready   = ($urandom_range(0, 99) < ready_pct);
        step();
      end
    end

    // Drain any access still in flight (bounded)
    drive_quiet();
    bus_if.mem_ready = 1'b1;
    repeat (W + T + 4) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected reads left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
